// File: rtl/rapid_pkg.sv
// Shared definitions for the rapid data-side blocks: data width and the
// TCM responder state encoding.
package rapid_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } tcm_state_t;

endpackage

// File: rtl/tcm_sram_1rw.sv
// Single-port word-addressed SRAM with byte enables and a registered read.
// The read register holds its value until the next read; the array itself is not reset.
module tcm_sram_1rw
  import rapid_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN/8-1:0] i_wmask,
  output logic [XLEN-1:0]   o_rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (i_wmask[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rdata <= '0;
    end else if (i_en && !i_we) begin
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/dcache_tcm_responder.sv
// Tightly-coupled data memory responder: one outstanding access, fixed LATENCY.
// Define DCACHE_TCM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping.
module dcache_tcm_responder
  import rapid_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_addr,
  input  logic              i_rw,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN/8-1:0] i_wmask,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rvalid,
  output logic              o_err,
  output logic [1:0]        o_state
);

  // Handshake: a request transfers on a rising edge with i_valid && o_ready.
  // o_ready is a pure function of state (high only in IDLE). Completion of
  // every access is a single-cycle o_rvalid pulse; o_err is qualified by it.

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DCACHE_TCM_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  tcm_state_t        state;
  logic [3:0]        cnt;
  logic [XLEN-1:0]   addr_q;
  logic              rw_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] wmask_q;
  logic              err_q;
  logic              rd_zero;

  logic [XLEN-1:0]   addr_sel;
  logic              oob;
  logic              rd_fire;
  logic              we_fire;
  logic [XLEN-1:0]   sram_rdata;
  logic              unused_addr_bits;

  // In IDLE the live address feeds the array so LATENCY=1 reads can fire on the accepting edge.
  assign addr_sel         = (state == IDLE) ? i_addr : addr_q;
  assign oob              = RANGE_EN & (|addr_sel[XLEN-1:AW+2]);
  assign unused_addr_bits = ^addr_sel[1:0];

  assign rd_fire = ((state == IDLE) && i_valid && !i_rw && (LATENCY == 1)) ||
                   ((state == BUSY) && (cnt == 4'd1) && !rw_q);
  assign we_fire = (state == RESPOND) && rw_q && !err_q;

  tcm_sram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    ((rd_fire && !oob) || we_fire),
    .i_we    (we_fire),
    .i_addr  (addr_sel[AW+1:2]),
    .i_wdata (wdata_q),
    .i_wmask (wmask_q),
    .o_rdata (sram_rdata)
  );

  assign o_ready = (state == IDLE);
  assign o_state = state;
  assign o_rdata = rd_zero ? '0 : sram_rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      err_q    <= 1'b0;
      rd_zero  <= 1'b0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
      // A faulting read must present zero without disturbing the array's read register.
      if (rd_fire) rd_zero <= oob;
      case (state)
        IDLE: begin
          if (i_valid) begin
            addr_q  <= i_addr;
            rw_q    <= i_rw;
            wdata_q <= i_wdata;
            wmask_q <= i_wmask;
            err_q   <= oob;
            if (LATENCY > 1) begin
              cnt   <= 4'(LATENCY - 1);
              state <= BUSY;
            end else begin
              cnt      <= '0;
              state    <= RESPOND;
              o_rvalid <= 1'b1;
              o_err    <= oob;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESPOND;
            o_rvalid <= 1'b1;
            o_err    <= err_q;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tcm_responder.sv
// Bench for dcache_tcm_responder: a LATENCY=1 and a LATENCY=4 instance checked
// against a word-array reference model with byte-mask merging.
module tb_dcache_tcm_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic        rw    [2];
  logic [31:0] wdata [2];
  logic [3:0]  wmask [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        rvalid[2];
  logic        err   [2];
  logic [1:0]  state [2];

  int          lat_of [2];
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] ref_rdata [2];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dcache_tcm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_addr(addr[0]), .i_rw(rw[0]), .i_wdata(wdata[0]), .i_wmask(wmask[0]),
    .o_rdata(rdata[0]), .o_rvalid(rvalid[0]), .o_err(err[0]), .o_state(state[0])
  );

  dcache_tcm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_addr(addr[1]), .i_rw(rw[1]), .i_wdata(wdata[1]), .i_wmask(wmask[1]),
    .o_rdata(rdata[1]), .o_rvalid(rvalid[1]), .o_err(err[1]), .o_state(state[1])
  );

  // One access on instance d; expectations come from the reference model.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m, input bit noise,
                     output logic [31:0] got, output int acc_cyc);
    int          k;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    idx = int'((a >> 2) % DEPTH);
`ifdef DCACHE_TCM_RANGE_CHECK_EN
    exp_err = (a >= DEPTH * 4);
`else
    exp_err = 1'b0;
`endif
    if (w) exp_rd = ref_rdata[d];
    else   exp_rd = exp_err ? 32'h0 : ref_mem[d][idx];

    k = 0;
    while (!ready[d] && k < 50) begin
      @(negedge clk); k++;
    end
    checks++;
    if (ready[d] !== 1'b1) begin
      errors++; $display("FAIL ready_wait: got %b want 1", ready[d]);
    end
    valid[d] = 1'b1; rw[d] = w; addr[d] = a; wdata[d] = wd; wmask[d] = m;
    @(posedge clk);
    acc_cyc = cyc;
    k = 0;
    while (k < 40) begin
      @(negedge clk); k++;
      if (rvalid[d]) break;
      valid[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rw[d] = 1'b1; addr[d] = $urandom_range(0, 127);
      wdata[d] = $urandom; wmask[d] = 4'hF;
    end
    valid[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom; rw[d] = $urandom_range(0, 1);
    got = rdata[d];
    checks++;
    if (rvalid[d] !== 1'b1 || k != lat_of[d]) begin
      errors++; $display("FAIL latency d%0d: got %0d want %0d", d, k, lat_of[d]);
    end
    checks++;
    if (ready[d] !== 1'b0 || state[d] !== 2'd2) begin
      errors++; $display("FAIL respond_state d%0d: ready %b state %0d want 0/2", d, ready[d], state[d]);
    end
    checks++;
    if (err[d] !== exp_err) begin
      errors++; $display("FAIL err d%0d a=%h: got %b want %b", d, a, err[d], exp_err);
    end
    checks++;
    if (rdata[d] !== exp_rd) begin
      errors++; $display("FAIL rdata d%0d a=%h w=%b: got %h want %h", d, a, w, rdata[d], exp_rd);
    end
    if (w && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
    if (!w) ref_rdata[d] = exp_rd;
    @(negedge clk);
    checks++;
    if (rvalid[d] !== 1'b0 || ready[d] !== 1'b1) begin
      errors++; $display("FAIL one_cycle_pulse d%0d: rvalid %b ready %b want 0/1", d, rvalid[d], ready[d]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wmask[d] = '0;
      ref_rdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (state[d] !== 2'd0 || rvalid[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        errors++; $display("FAIL reset_outputs d%0d: state %0d rvalid %b err %b rdata %h want 0", d, state[d], rvalid[d], err[d], rdata[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_ready d%0d: got %b want 1", d, ready[d]);
      end
    end
  endtask

  task automatic test_preload;
    logic [31:0] got;
    int          c;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++)
        txn(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, got, c);
  endtask

  task automatic test_basic;
    logic [31:0] got;
    int          c;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, got, c);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got, c);
    checks++;
    if (got !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_read: got %h want deadbeef", got);
    end
  endtask

  task automatic test_byte_mask;
    logic [31:0] got;
    int          c;
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, got, c);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, got, c);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, got, c);
    checks++;
    if (got !== 32'h11BB33DD) begin
      errors++; $display("FAIL byte_mask: got %h want 11bb33dd", got);
    end
  endtask

  task automatic test_latency4;
    logic [31:0] got;
    int          c;
    txn(1, 1'b1, 32'h10, 32'hC0FFEE11, 4'hF, 1'b1, got, c);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, got, c);
    checks++;
    if (got !== 32'hC0FFEE11) begin
      errors++; $display("FAIL latency4_read: got %h want c0ffee11", got);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] got;
    int          c;
    txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, got, c);
    valid[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h1; wmask[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    checks++;
    if (state[1] !== 2'd1) begin
      errors++; $display("FAIL abort_busy: state %0d want 1", state[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state[1] !== 2'd0 || rvalid[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      errors++; $display("FAIL abort_outputs: state %0d rvalid %b err %b rdata %h want 0", state[1], rvalid[1], err[1], rdata[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    @(negedge clk);
    checks++;
    if (ready[1] !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %b want 1", ready[1]);
    end
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, got, c);
    checks++;
    if (got !== 32'hCAFEF00D) begin
      errors++; $display("FAIL abort_no_commit: got %h want cafef00d", got);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] got;
    int          c;
    txn(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 1'b0, got, c);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, got, c);
    checks++;
`ifdef DCACHE_TCM_RANGE_CHECK_EN
    if (got !== 32'h0) begin
      errors++; $display("FAIL oob_read: got %h want 0", got);
    end
`else
    if (got !== 32'h0BADC0DE) begin
      errors++; $display("FAIL oob_wrap: got %h want 0badc0de", got);
    end
`endif
    txn(0, 1'b1, 32'h1004, 32'h77665544, 4'hF, 1'b0, got, c);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, got, c);
  endtask

  task automatic test_rdata_hold;
    logic [31:0] got;
    int          c;
    txn(0, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 1'b0, got, c);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, got, c);
    txn(0, 1'b1, 32'h34, 32'h12345678, 4'hF, 1'b0, got, c);
    txn(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 1'b0, got, c);
    repeat (3) @(negedge clk);
    checks++;
    if (rdata[0] !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL rdata_hold: got %h want 5a5a5a5a", rdata[0]);
    end
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, got, c);
    checks++;
    if (got !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL zero_mask: got %h want 5a5a5a5a", got);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    int          c0;
    int          c1;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 32'h50, 32'h600DF00D, 4'hF, 1'b0, got, c0);
      txn(d, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, got, c1);
      checks++;
      if (c1 - c0 != lat_of[d] + 1) begin
        errors++; $display("FAIL throughput d%0d: got %0d want %0d", d, c1 - c0, lat_of[d] + 1);
      end
      checks++;
      if (got !== 32'h600DF00D) begin
        errors++; $display("FAIL raw_b2b d%0d: got %h want 600df00d", d, got);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] got;
    logic [31:0] a;
    int          c;
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), got, c);
    end
  endtask

  initial begin
    lat_of[0] = 1;
    lat_of[1] = 4;
    test_reset();
    test_preload();
    test_basic();
    test_byte_mask();
    test_latency4();
    test_reset_abort();
    test_out_of_range();
    test_rdata_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
